ahb_burst_sched: RTL and testbench

AHB_BURST_SCHED -- requirements
Module: ahb_burst_sched

---
 rtl/ahb_burst_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_ahb_burst_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_burst_sched.sv
// rtl/ahb_burst_sched.sv - two-requester AHB burst master scheduler
//
// Purpose: accepts burst commands from two requesters with round-robin
// arbitration and drives them onto an AHB-style master address phase.
// A one-deep data-phase tracker reports completed beats and ERROR
// terminations.
//
// Ports:
//   hclk, hresetn          clock; synchronous active-high reset
//   req_valid/req_ready    per-requester command handshake (ready is a 1-cycle accept pulse)
//   req_addr/burst/size/write  per-requester command fields, packed per requester
//   Haddr/Hburst/Hsize/Htrans/Hwrite/Hprot/Hmastlock  address-phase outputs
//   Hready_out, Hresp      bus ready and response from the slave
//   grant_id               requester owning the current address phase
//   beat_ack/beat_id       OKAY data-phase completion pulse and its owner
//   xfer_err               pulse when a burst ends with an ERROR response
module ahb_burst_sched #(
  parameter int ADDR_W = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [5:0]            req_burst,
  input  logic [5:0]            req_size,
  input  logic [1:0]            req_write,
  output logic [ADDR_W-1:0]     Haddr,
  output logic [2:0]            Hburst,
  output logic [2:0]            Hsize,
  output logic [1:0]            Htrans,
  output logic                  Hwrite,
  output logic [3:0]            Hprot,
  output logic                  Hmastlock,
  input  logic                  Hready_out,
  input  logic                  Hresp,
  output logic                  grant_id,
  output logic                  beat_ack,
  output logic                  beat_id,
  output logic                  xfer_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Total beats implied by an HBURST code; undefined-length INCR is issued as a single beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: burst_beats = 5'd4;
      3'd4, 3'd5: burst_beats = 5'd8;
      3'd6, 3'd7: burst_beats = 5'd16;
      default:    burst_beats = 5'd1;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;       // requester granted most recently (tie pointer)
  logic [4:0]        beats_q, beats_d;     // beats remaining including the one on the bus
  logic              dp_valid_q, dp_valid_d;
  logic              dp_owner_q, dp_owner_d;

  logic              win;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_burst;
  logic [2:0]        sel_size_raw;
  logic [2:0]        sel_size;
  logic              sel_write;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;
  logic              is_wrap;
  logic              addr_phase_ok;

  // Arbitration and selected command
  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
    accept       = (state_q == ST_IDLE) && Hready_out && (|req_valid) && !hresetn;
    sel_addr     = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_burst    = win ? req_burst[5:3] : req_burst[2:0];
    sel_size_raw = win ? req_size[5:3]  : req_size[2:0];
    sel_write    = win ? req_write[1]   : req_write[0];
    sel_size     = (sel_size_raw > 3'd2) ? 3'd2 : sel_size_raw;
  end

  // Next beat address; wrapping bursts keep the bits above the wrap boundary.
  always_comb begin
    incr_addr = haddr_q + (ONE << hsize_q);
    is_wrap   = !hburst_q[0] && (hburst_q[2:1] != 2'd0);
    wrap_mask = (ADDR_W'(burst_beats(hburst_q)) << hsize_q) - ONE;
    next_addr = is_wrap ? ((haddr_q & ~wrap_mask) | (incr_addr & wrap_mask)) : incr_addr;
  end

  assign addr_phase_ok = Hready_out && htrans_q[1];

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    hburst_d   = hburst_q;
    hsize_d    = hsize_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beats_d    = beats_q;
    dp_valid_d = dp_valid_q;
    dp_owner_d = dp_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          haddr_d  = sel_addr & ~((ONE << sel_size) - ONE);
          hburst_d = (sel_burst == 3'd1) ? 3'd0 : sel_burst;
          hsize_d  = sel_size;
          hwrite_d = sel_write;
          htrans_d = HT_NONSEQ;
          beats_d  = burst_beats(sel_burst);
          grant_d  = win;
          last_d   = win;
          state_d  = ST_BURST;
        end
      end
      ST_BURST: begin
        if (addr_phase_ok) begin
          if (beats_q > 5'd1) begin
            htrans_d = HT_SEQ;
            haddr_d  = next_addr;
            beats_d  = beats_q - 5'd1;
          end else begin
            htrans_d = HT_IDLE;
            beats_d  = 5'd0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (Hready_out) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The tracker follows the address phase the bus just accepted.
    if (Hready_out) begin
      dp_valid_d = addr_phase_ok;
      if (addr_phase_ok) begin
        dp_owner_d = grant_q;
      end
    end

    // First ERROR cycle: pull the bus to IDLE and drop the rest of the burst.
    if (dp_valid_q && Hresp && !Hready_out) begin
      htrans_d = HT_IDLE;
      beats_d  = 5'd0;
      state_d  = ST_ERR;
    end
  end

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      hburst_q   <= 3'd0;
      hsize_q    <= 3'd0;
      htrans_q   <= HT_IDLE;
      hwrite_q   <= 1'b0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      beats_q    <= 5'd0;
      dp_valid_q <= 1'b0;
      dp_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      hburst_q   <= hburst_d;
      hsize_q    <= hsize_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beats_q    <= beats_d;
      dp_valid_q <= dp_valid_d;
      dp_owner_q <= dp_owner_d;
    end
  end

  // Handshake and completion outputs are same-cycle, masked while reset is held.
  assign req_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign beat_ack  = !hresetn && dp_valid_q && Hready_out && !Hresp;
  assign beat_id   = beat_ack && dp_owner_q;
  assign xfer_err  = !hresetn && (state_q == ST_ERR) && Hready_out && Hresp;

  assign Haddr     = haddr_q;
  assign Hburst    = hburst_q;
  assign Hsize     = hsize_q;
  assign Htrans    = htrans_q;
  assign Hwrite    = hwrite_q;
  assign grant_id  = grant_q;
  assign Hprot     = 4'b0011;
  assign Hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_burst_sched.sv
// tb/tb_ahb_burst_sched.sv - directed self-checking bench for ahb_burst_sched
module tb_ahb_burst_sched;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [5:0]  req_burst;
  logic [5:0]  req_size;
  logic [1:0]  req_write;
  logic [31:0] Haddr;
  logic [2:0]  Hburst;
  logic [2:0]  Hsize;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [3:0]  Hprot;
  logic        Hmastlock;
  logic        Hready_out;
  logic        Hresp;
  logic        grant_id;
  logic        beat_ack;
  logic        beat_id;
  logic        xfer_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_a [16];
  logic [2:0]  exp_burst;
  logic [2:0]  exp_size;
  logic        exp_write;
  int          acks;

  ahb_burst_sched #(.ADDR_W(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_burst(req_burst), .req_size(req_size), .req_write(req_write),
    .Haddr(Haddr), .Hburst(Hburst), .Hsize(Hsize), .Htrans(Htrans),
    .Hwrite(Hwrite), .Hprot(Hprot), .Hmastlock(Hmastlock),
    .Hready_out(Hready_out), .Hresp(Hresp), .grant_id(grant_id),
    .beat_ack(beat_ack), .beat_id(beat_id), .xfer_err(xfer_err)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Issues a command with valid mask vmask (fields preloaded by caller), expects
  // requester id to win and walks n address phases against exp_a.
  task automatic run_burst(input logic [1:0] vmask, input int id, input int n);
    req_valid = vmask;
    #1;
    chk("req_ready", req_ready, (id == 1) ? 2'b10 : 2'b01);
    acks = 0;
    for (int k = 0; k < n; k++) begin
      step();
      chk("htrans", Htrans, (k == 0) ? 2'd2 : 2'd3);
      chk("haddr", Haddr, exp_a[k]);
      chk("grant_id", grant_id, id);
      chk("no_grant_in_burst", req_ready, 2'b00);
      if (k == 0) begin
        chk("hburst", Hburst, exp_burst);
        chk("hsize", Hsize, exp_size);
        chk("hwrite", Hwrite, exp_write);
      end
      if (beat_ack) begin
        acks++;
        chk("beat_id", beat_id, id);
      end
      if (k == n - 1) req_valid = 2'b00;
    end
    step();
    chk("htrans_end", Htrans, 2'd0);
    if (beat_ack) begin
      acks++;
      chk("beat_id_end", beat_id, id);
    end
    step();
    chk("drained", beat_ack, 1'b0);
    chk("ack_count", acks, n);
  endtask

  initial begin
    hresetn    = 1'b1;
    req_valid  = 2'b00;
    req_addr   = '0;
    req_burst  = '0;
    req_size   = '0;
    req_write  = '0;
    Hready_out = 1'b1;
    Hresp      = 1'b0;
    repeat (3) step();

    // Reset state, with commands pending
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_htrans", Htrans, 2'd0);
    chk("rst_haddr", Haddr, 32'h0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_beat_ack", beat_ack, 1'b0);
    chk("rst_xfer_err", xfer_err, 1'b0);
    chk("hprot", Hprot, 4'b0011);
    chk("hmastlock", Hmastlock, 1'b0);
    req_valid = 2'b00;
    hresetn   = 1'b0;
    step();

    // Tie after reset goes to req0: single write at 0x100
    req_addr  = {32'h0000_0020, 32'h0000_0100};
    req_burst = {3'd3, 3'd0};
    req_size  = {3'd2, 3'd2};
    req_write = 2'b01;
    exp_a[0] = 32'h100; exp_burst = 3'd0; exp_size = 3'd2; exp_write = 1'b1;
    run_burst(2'b11, 0, 1);

    // Next tie goes to req1: INCR4 at 0x20
    exp_a[0] = 32'h20; exp_a[1] = 32'h24; exp_a[2] = 32'h28; exp_a[3] = 32'h2C;
    exp_burst = 3'd3; exp_size = 3'd2; exp_write = 1'b0;
    run_burst(2'b11, 1, 4);

    // Tie back to req0: WRAP4 at 0x38
    req_addr[31:0] = 32'h38;
    req_burst[2:0] = 3'd2;
    req_write      = 2'b00;
    exp_a[0] = 32'h38; exp_a[1] = 32'h3C; exp_a[2] = 32'h30; exp_a[3] = 32'h34;
    exp_burst = 3'd2; exp_size = 3'd2; exp_write = 1'b0;
    run_burst(2'b11, 0, 4);

    // req1 alone: INCR issued as SINGLE, halfword, misaligned address forced to 0x122
    req_addr[63:32] = 32'h123;
    req_burst[5:3]  = 3'd1;
    req_size[5:3]   = 3'd1;
    req_write       = 2'b10;
    exp_a[0] = 32'h122; exp_burst = 3'd0; exp_size = 3'd1; exp_write = 1'b1;
    run_burst(2'b10, 1, 1);

    // req0 alone: size 5 clamped to word, INCR4 from 0x3FE aligned to 0x3FC
    req_addr[31:0] = 32'h3FE;
    req_burst[2:0] = 3'd3;
    req_size[2:0]  = 3'd5;
    req_write      = 2'b00;
    exp_a[0] = 32'h3FC; exp_a[1] = 32'h400; exp_a[2] = 32'h404; exp_a[3] = 32'h408;
    exp_burst = 3'd3; exp_size = 3'd2; exp_write = 1'b0;
    run_burst(2'b01, 0, 4);

    // req1: INCR4 crossing the top of the address space
    req_addr[63:32] = 32'hFFFF_FFF8;
    req_burst[5:3]  = 3'd3;
    req_size[5:3]   = 3'd2;
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    exp_burst = 3'd3; exp_size = 3'd2; exp_write = 1'b0;
    run_burst(2'b10, 1, 4);

    // req0: WRAP8 halfword at 0x0E wraps inside a 16-byte window
    req_addr[31:0] = 32'h0E;
    req_burst[2:0] = 3'd4;
    req_size[2:0]  = 3'd1;
    exp_a[0] = 32'h0E; exp_a[1] = 32'h00; exp_a[2] = 32'h02; exp_a[3] = 32'h04;
    exp_a[4] = 32'h06; exp_a[5] = 32'h08; exp_a[6] = 32'h0A; exp_a[7] = 32'h0C;
    exp_burst = 3'd4; exp_size = 3'd1; exp_write = 1'b0;
    run_burst(2'b01, 0, 8);

    // Wait states: INCR8 at 0x0, three stalled cycles while beat 2 is on the bus
    req_addr[31:0] = 32'h0;
    req_burst[2:0] = 3'd5;
    req_size[2:0]  = 3'd2;
    req_valid = 2'b01;
    #1;
    chk("ws_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("ws_nonseq", Htrans, 2'd2);
    chk("ws_addr0", Haddr, 32'h0);
    acks = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      Hready_out = 1'b0;
      #1;
      chk("ws_hold_addr", Haddr, 32'h4);
      chk("ws_hold_trans", Htrans, 2'd3);
      chk("ws_hold_ack", beat_ack, 1'b0);
      step();
    end
    Hready_out = 1'b1;
    #1;
    chk("ws_resume_addr", Haddr, 32'h4);
    if (beat_ack) acks++;
    step();
    chk("ws_addr8", Haddr, 32'h8);
    chk("ws_seq8", Htrans, 2'd3);
    if (beat_ack) acks++;
    for (int k = 3; k < 8; k++) begin
      step();
      chk("ws_addr", Haddr, 32'(4 * k));
      if (beat_ack) acks++;
    end
    step();
    chk("ws_idle", Htrans, 2'd0);
    if (beat_ack) acks++;
    chk("ws_ack_count", acks, 8);
    step();

    // ERROR on beat 2 of INCR4 at 0x40
    req_addr[31:0] = 32'h40;
    req_burst[2:0] = 3'd3;
    req_valid = 2'b01;
    #1;
    chk("err_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("err_nonseq_addr", Haddr, 32'h40);
    acks = 0;
    step();
    chk("err_seq_addr", Haddr, 32'h44);
    if (beat_ack) acks++;
    step();
    Hready_out = 1'b0;
    Hresp      = 1'b1;
    #1;
    chk("err1_ack", beat_ack, 1'b0);
    chk("err1_xfer_err", xfer_err, 1'b0);
    chk("err1_htrans", Htrans, 2'd3);
    step();
    Hready_out = 1'b1;
    #1;
    chk("err2_htrans", Htrans, 2'd0);
    chk("err2_haddr", Haddr, 32'h48);
    chk("err2_xfer_err", xfer_err, 1'b1);
    chk("err2_ack", beat_ack, 1'b0);
    step();
    Hresp = 1'b0;
    #1;
    chk("err3_xfer_err", xfer_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("err_no_seq", Htrans, 2'd0);
      if (beat_ack) acks++;
      step();
    end
    chk("err_ack_count", acks, 1);

    // Reset in the middle of an INCR8 burst
    req_addr[31:0] = 32'h200;
    req_burst[2:0] = 3'd5;
    req_valid = 2'b01;
    #1;
    chk("mid_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    chk("mid_seq", Htrans, 2'd3);
    hresetn = 1'b1;
    #1;
    chk("mid_rst_ack", beat_ack, 1'b0);
    step();
    chk("mid_rst_htrans", Htrans, 2'd0);
    chk("mid_rst_haddr", Haddr, 32'h0);
    chk("mid_rst_xfer_err", xfer_err, 1'b0);
    hresetn = 1'b0;
    step();
    chk("post_rst_htrans", Htrans, 2'd0);
    chk("post_rst_ack", beat_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
